// File: rtl/peripheral_burst_master_axi4.sv
// rtl/peripheral_burst_master_axi4.sv - Wishbone-style burst initiator with CTI/BTE for on-chip RAM fill/readback
module peripheral_burst_master_axi4 #(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int LENW = 4
) (
    input  logic            axi4_clk_i,
    input  logic            axi4_rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [LENW-1:0] cmd_len_i,
    input  logic [1:0]      cmd_bte_i,
    input  logic            wr_valid_i,
    output logic            wr_ready_o,
    input  logic [DW-1:0]   wr_dat_i,
    input  logic [3:0]      wr_sel_i,
    output logic            rd_valid_o,
    output logic [DW-1:0]   rd_dat_o,
    output logic            done_o,
    output logic            err_o,
    output logic [AW-1:0]   axi4_adr_o,
    output logic [DW-1:0]   axi4_dat_o,
    output logic [3:0]      axi4_sel_o,
    output logic            axi4_we_o,
    output logic [1:0]      axi4_bte_o,
    output logic [2:0]      axi4_cti_o,
    output logic            axi4_cyc_o,
    output logic            axi4_stb_o,
    input  logic            axi4_ack_i,
    input  logic            axi4_err_i,
    input  logic [DW-1:0]   axi4_dat_i
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    localparam logic [AW-3:0] WRAP4_MASK  = (AW-2)'(3);
    localparam logic [AW-3:0] WRAP8_MASK  = (AW-2)'(7);
    localparam logic [AW-3:0] WRAP16_MASK = (AW-2)'(15);

    state_t          state_q, state_d;
    logic            we_q;
    logic [AW-1:0]   adr_q;
    logic [LENW-1:0] len_q;
    logic [LENW-1:0] beat_q;
    logic [1:0]      bte_q;
    logic            err_q;
    logic            rd_valid_q;
    logic [DW-1:0]   rd_dat_q;

    logic            in_bus;
    logic            stb;
    logic            beat_ack;
    logic            beat_err;
    logic            last_beat;
    logic [AW-3:0]   word_q;
    logic [AW-3:0]   word_inc;
    logic [AW-3:0]   wrap_mask;
    logic [AW-3:0]   word_next;

    assign in_bus    = (state_q == S_BUS);
    assign stb       = in_bus & (we_q ? wr_valid_i : 1'b1);
    // Error wins over ack: an errored beat never counts as a data beat.
    assign beat_err  = stb & axi4_err_i;
    assign beat_ack  = stb & axi4_ack_i & ~axi4_err_i;
    assign last_beat = (beat_q == len_q);

    assign word_q     = adr_q[AW-1:2];
    assign word_inc   = word_q + (AW-2)'(1);
    assign axi4_adr_o = adr_q;
    assign axi4_dat_o = wr_dat_i;
    assign rd_valid_o = rd_valid_q;
    assign rd_dat_o   = rd_dat_q;

    // Next word address: only the bits inside the wrap field advance, upper bits are kept.
    always_comb begin
        wrap_mask = '1;
        case (bte_q)
            2'd1:    wrap_mask = WRAP4_MASK;
            2'd2:    wrap_mask = WRAP8_MASK;
            2'd3:    wrap_mask = WRAP16_MASK;
            default: wrap_mask = '1;
        endcase
        word_next = (word_q & ~wrap_mask) | (word_inc & wrap_mask);
    end

    // Next-state and bus/handshake output decode.
    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        axi4_cyc_o  = 1'b0;
        axi4_stb_o  = 1'b0;
        axi4_we_o   = 1'b0;
        axi4_bte_o  = 2'b00;
        axi4_cti_o  = 3'b000;
        axi4_sel_o  = 4'h0;
        wr_ready_o  = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready_o = ~axi4_rst_i;
                if (cmd_valid_i) state_d = S_BUS;
            end
            S_BUS: begin
                axi4_cyc_o = 1'b1;
                axi4_stb_o = stb;
                axi4_we_o  = we_q;
                axi4_bte_o = bte_q;
                axi4_sel_o = we_q ? wr_sel_i : 4'hF;
                if (len_q == '0)    axi4_cti_o = 3'b000;
                else if (last_beat) axi4_cti_o = 3'b111;
                else                axi4_cti_o = 3'b010;
                wr_ready_o = beat_ack & we_q;
                if (beat_err || (beat_ack && last_beat)) state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, command latch, beat counting, address stepping and read capture.
    always_ff @(posedge axi4_clk_i or posedge axi4_rst_i) begin
        if (axi4_rst_i) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            adr_q      <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            bte_q      <= 2'b00;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_dat_q   <= '0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= 1'b0;
            if (state_q == S_IDLE && cmd_valid_i) begin
                we_q   <= cmd_we_i;
                adr_q  <= cmd_adr_i;
                len_q  <= cmd_len_i;
                bte_q  <= cmd_bte_i;
                beat_q <= '0;
                err_q  <= 1'b0;
            end
            if (beat_err) err_q <= 1'b1;
            if (beat_ack) begin
                beat_q <= beat_q + LENW'(1);
                adr_q  <= {word_next, adr_q[1:0]};
                if (!we_q) begin
                    rd_valid_q <= 1'b1;
                    rd_dat_q   <= axi4_dat_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_peripheral_burst_master_axi4.sv
// tb/tb_peripheral_burst_master_axi4.sv - randomized bench for peripheral_burst_master_axi4 with RAM/slave model
module tb_peripheral_burst_master_axi4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [3:0]  cmd_len;
    logic [1:0]  cmd_bte;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_dat;
    logic [3:0]  wr_sel;
    logic        rd_valid;
    logic [31:0] rd_dat;
    logic        done, err;
    logic [31:0] b_adr, b_dat_o, b_dat_i;
    logic [3:0]  b_sel;
    logic        b_we, b_cyc, b_stb, b_ack, b_err;
    logic [1:0]  b_bte;
    logic [2:0]  b_cti;

    logic [31:0] mem [256];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    peripheral_burst_master_axi4 dut (
        .axi4_clk_i (clk),
        .axi4_rst_i (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_adr_i  (cmd_adr),
        .cmd_len_i  (cmd_len),
        .cmd_bte_i  (cmd_bte),
        .wr_valid_i (wr_valid),
        .wr_ready_o (wr_ready),
        .wr_dat_i   (wr_dat),
        .wr_sel_i   (wr_sel),
        .rd_valid_o (rd_valid),
        .rd_dat_o   (rd_dat),
        .done_o     (done),
        .err_o      (err),
        .axi4_adr_o (b_adr),
        .axi4_dat_o (b_dat_o),
        .axi4_sel_o (b_sel),
        .axi4_we_o  (b_we),
        .axi4_bte_o (b_bte),
        .axi4_cti_o (b_cti),
        .axi4_cyc_o (b_cyc),
        .axi4_stb_o (b_stb),
        .axi4_ack_i (b_ack),
        .axi4_err_i (b_err),
        .axi4_dat_i (b_dat_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Runs one command against the RAM model; err_beat/stall_beat < 0 disables them.
    task automatic run_cmd(input logic we, input logic [31:0] adr, input int len, input logic [1:0] bte,
                           input int err_beat, input int stall_beat, input bit fixed, input logic [31:0] dbase);
        logic [31:0] exp_adr [17];
        logic [31:0] wdat [17];
        logic [3:0]  wsel [17];
        logic [31:0] rq [$];
        logic [31:0] m;
        logic        stb_e;
        int beat, nrd, stall_left, base, n, w, b;
        bit aborted, finished, expect_done, stall_done;
        base = int'(adr >> 2);
        b = int'(bte);
        for (int i = 0; i <= 16; i++) begin
            if (b == 0) w = base + i;
            else begin
                n = 4 << (b - 1);
                w = base - (base % n) + ((base % n) + i) % n;
            end
            exp_adr[i] = 32'(w * 4);
            wdat[i] = fixed ? dbase + 32'(i) : $urandom;
            wsel[i] = fixed ? 4'hF : 4'($urandom_range(1, 15));
        end
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = 4'(len); cmd_bte = bte;
        #1 check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        beat = 0; nrd = 0; stall_left = 0;
        aborted = 0; finished = 0; expect_done = 0; stall_done = 0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (rd_valid) begin
                if (rq.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    check("rd_dat", rd_dat, rq.pop_front());
                    nrd++;
                end
            end
            check("done", done, expect_done);
            if (expect_done) begin
                check("err", err, aborted);
                check("cyc_after_done", b_cyc, 0);
                check("cmd_ready_done", cmd_ready, 0);
                finished = 1;
            end else begin
                if (we && beat == stall_beat && !stall_done) begin
                    stall_left = 3;
                    stall_done = 1;
                end
                if (stall_left > 0) begin
                    wr_valid = 1'b0;
                    stall_left--;
                end else wr_valid = we ? ($urandom_range(0, 4) != 0) : 1'($urandom);
                wr_dat  = wdat[beat];
                wr_sel  = wsel[beat];
                b_ack   = ($urandom_range(0, 3) != 0);
                b_err   = (beat == err_beat);
                b_dat_i = mem[b_adr[9:2]];
                stb_e   = we ? wr_valid : 1'b1;
                #1;
                check("cyc", b_cyc, 1);
                check("stb", b_stb, stb_e);
                check("adr", b_adr, exp_adr[beat]);
                check("cti", b_cti, (len == 0) ? 0 : ((beat == len) ? 7 : 2));
                check("we", b_we, we);
                check("bte", b_bte, bte);
                check("sel", b_sel, we ? wsel[beat] : 4'hF);
                if (we) check("wdat", b_dat_o, wdat[beat]);
                check("wr_ready", wr_ready, stb_e && b_ack && !b_err && we);
                if (stb_e && b_err) begin
                    aborted = 1;
                    expect_done = 1;
                end else if (stb_e && b_ack) begin
                    if (we) begin
                        m = mem[exp_adr[beat][9:2]];
                        for (int k = 0; k < 4; k++)
                            if (wsel[beat][k]) m[k*8 +: 8] = wdat[beat][k*8 +: 8];
                        mem[exp_adr[beat][9:2]] = m;
                    end else rq.push_back(mem[exp_adr[beat][9:2]]);
                    if (beat == len) expect_done = 1;
                    beat++;
                end
                @(posedge clk); #1;
            end
        end
        if (!finished) check("timeout", 0, 1);
        b_ack = 1'b0; b_err = 1'b0; wr_valid = 1'b0;
        check("rd_beats", nrd, we ? 0 : beat);
        check("rd_left", rq.size(), 0);
    endtask

    initial begin
        int eb, sb, ln;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_len = 0; cmd_bte = 0;
        wr_valid = 0; wr_dat = 0; wr_sel = 0; b_ack = 0; b_err = 0; b_dat_i = 0;
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_cyc", b_cyc, 0);
        check("rst_stb", b_stb, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_adr", b_adr, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("idle_cmd_ready", cmd_ready, 1);

        run_cmd(1'b1, 32'h10, 0, 2'd0, -1, -1, 1'b1, 32'hA5A5_A5A5);
        check("mem_single", mem[4], 32'hA5A5_A5A5);
        run_cmd(1'b0, 32'h10, 0, 2'd0, -1, -1, 1'b0, 32'h0);
        run_cmd(1'b1, 32'h0, 7, 2'd0, -1, -1, 1'b1, 32'h0);
        run_cmd(1'b0, 32'h0, 7, 2'd0, -1, -1, 1'b0, 32'h0);
        run_cmd(1'b0, 32'h28, 3, 2'd1, -1, -1, 1'b0, 32'h0);
        run_cmd(1'b0, 32'h34, 11, 2'd2, -1, -1, 1'b0, 32'h0);
        run_cmd(1'b1, 32'h80, 5, 2'd0, -1, 2, 1'b0, 32'h0);
        run_cmd(1'b0, 32'h80, 5, 2'd0, -1, -1, 1'b0, 32'h0);
        run_cmd(1'b0, 32'h40, 5, 2'd0, 2, -1, 1'b0, 32'h0);

        // Reset in the middle of a read burst.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h40; cmd_len = 4'd7; cmd_bte = 2'd0;
        @(posedge clk); #1;
        cmd_valid = 1'b0; b_ack = 1'b1; b_dat_i = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1 check("cyc_mid_burst", b_cyc, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_cyc", b_cyc, 0);
        check("mid_rst_stb", b_stb, 0);
        check("mid_rst_adr", b_adr, 0);
        check("mid_rst_cti", b_cti, 0);
        check("mid_rst_we", b_we, 0);
        check("mid_rst_sel", b_sel, 0);
        check("mid_rst_bte", b_bte, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_rd_valid", rd_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0; b_ack = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_done_after_rst", done, 0);
        end
        run_cmd(1'b0, 32'h40, 3, 2'd0, -1, -1, 1'b0, 32'h0);

        for (int t = 0; t < 24; t++) begin
            ln = $urandom_range(0, 15);
            eb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, ln) : -1;
            sb = ($urandom_range(0, 1) == 0) ? $urandom_range(0, ln) : -1;
            run_cmd(1'($urandom), 32'($urandom_range(0, 200) * 4), ln, 2'($urandom),
                    eb, sb, 1'b0, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
